// File: rtl/lab9_mult_arb_pkg.sv
// lab9_mult_arb_pkg -- shared types and default sizing for the multiplier arbiter.
package lab9_mult_arb_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lab9_rr_arb2.sv
// lab9_rr_arb2 -- two-way round-robin pick.
// pick=0 selects requester 0, pick=1 selects requester 1.
// last=1 means requester 1 was served most recently.
module lab9_rr_arb2
    import lab9_mult_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick,
    output logic valid
);

    // A lone request always wins; a tie goes to whoever was not served last
    always_comb begin
        valid = req0 | req1;
        pick  = 1'b0;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

endmodule

// File: rtl/lab9_mult_arbiter.sv
// lab9_mult_arbiter -- shares one serial multiplier between two requesters.
// Sequence per transaction: IDLE (grant) -> LOAD (start strobe) -> WAIT -> DONE.
// Optional WAIT-state watchdog: define MULT_ARB_TIMEOUT_EN.
module lab9_mult_arbiter
    import lab9_mult_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               done0,
    output logic               done1,
    output logic [2*WIDTH-1:0] prod0,
    output logic [2*WIDTH-1:0] prod1,
    output logic               err,
    output logic               busy,
    output logic               mul_rst,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_out,
    input  logic               mul_valid
);

    state_t           state;
    state_t           state_next;
    logic             owner;
    logic             last;
    logic             pick;
    logic             pick_valid;
    logic             grant_fire;
    logic             finish;
    logic             timed_out;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    lab9_rr_arb2 u_arb (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .pick  (pick),
        .valid (pick_valid)
    );

    assign grant_fire = (state == ST_IDLE) && pick_valid;
    assign finish     = (state == ST_WAIT) && (mul_valid || timed_out);

    // Grants are combinational in IDLE so the requester sees the accept in the capture cycle
    assign gnt0    = rst_n && grant_fire && !pick;
    assign gnt1    = rst_n && grant_fire && pick;
    assign busy    = (state != ST_IDLE);
    assign mul_rst = !rst_n || (state == ST_LOAD);
    assign mul_a   = op_a;
    assign mul_b   = op_b;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one cycle each in LOAD and DONE, WAIT until result (or watchdog)
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (pick_valid) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_WAIT;
            ST_WAIT: if (finish) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the winner's operands and remember it for the round-robin tie-break
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else if (grant_fire) begin
            op_a  <= pick ? a1 : a0;
            op_b  <= pick ? b1 : b0;
            owner <= pick;
            last  <= pick;
        end
    end

    // Store the result for the owner only and pulse its done in the DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod0 <= '0;
            prod1 <= '0;
            done0 <= 1'b0;
            done1 <= 1'b0;
        end else begin
            done0 <= finish && !owner;
            done1 <= finish && owner;
            if (finish && !owner) prod0 <= mul_valid ? mul_out : '0;
            if (finish && owner)  prod1 <= mul_valid ? mul_out : '0;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Count cycles spent in WAIT; cleared in every other state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // A real result in the last allowed cycle still wins over the watchdog
    assign timed_out = (state == ST_WAIT) && !mul_valid && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Flag a watchdog-terminated transaction alongside its done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= finish && timed_out;
        end
    end

    assign err = err_q;
`else
    // Without the watchdog the timeout parameter has no effect
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign timed_out      = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_lab9_mult_arbiter.sv
// tb_lab9_mult_arbiter -- randomized scoreboard bench for lab9_mult_arbiter.
// Builds with or without MULT_ARB_TIMEOUT_EN; the stuck-multiplier case adapts.
module tb_lab9_mult_arbiter;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 12;
    localparam int PW      = 2 * WIDTH;

    typedef struct {
        int            owner;
        logic [PW-1:0] prod;
        logic          err;
    } txn_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0  = 1'b0;
    logic             req1  = 1'b0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             gnt0, gnt1, done0, done1, err, busy, mul_rst;
    logic [PW-1:0]    prod0, prod1;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic [PW-1:0]    mul_out   = '0;
    logic             mul_valid = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int gnt_cycle   = 0;

    // Reference model state: expected grant order, expected completions, held products
    int            gnt_q[$];
    txn_t          done_q[$];
    logic [PW-1:0] exp_prod [2];
    int            model_last = 1;

    // Multiplier model controls
    bit stuck     = 1'b0;
    int force_lat = 0;
    int next_lat  = 1;
    int lat_last  = 1;
    int mul_cnt   = 0;

    lab9_mult_arbiter #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .prod0     (prod0),
        .prod1     (prod1),
        .err       (err),
        .busy      (busy),
        .mul_rst   (mul_rst),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_out   (mul_out),
        .mul_valid (mul_valid)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used for latency checks
    always @(posedge clk) cycle <= cycle + 1;

    // Choose the next multiply latency away from the active edge
    always @(negedge clk) next_lat <= (force_lat != 0) ? force_lat : int'($urandom_range(1, 8));

    // Serial multiplier model: valid appears next_lat cycles after the load strobe
    always @(posedge clk) begin
        if (mul_rst) begin
            mul_out   <= PW'(mul_a) * PW'(mul_b);
            mul_cnt   <= next_lat - 1;
            lat_last  <= next_lat;
            mul_valid <= (next_lat == 1) && !stuck;
        end else if (mul_cnt > 0) begin
            mul_cnt <= mul_cnt - 1;
            if (mul_cnt == 1 && !stuck) mul_valid <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: compare every grant and completion against the scoreboard
    always @(negedge clk) begin : monitor
        int   who;
        txn_t t;
        if (rst_n) begin
            if (gnt0 || gnt1) begin
                checkOutput("gnt_onehot", int'(gnt0) + int'(gnt1), 1);
                checkOutput("gnt_while_busy", busy, 0);
                who = gnt1 ? 1 : 0;
                if (gnt_q.size() == 0) checkOutput("gnt_unexpected", who, -1);
                else checkOutput("gnt_owner", who, gnt_q.pop_front());
                gnt_cycle = cycle;
            end
            if (done0 || done1) begin
                checkOutput("done_onehot", int'(done0) + int'(done1), 1);
                who = done1 ? 1 : 0;
                if (done_q.size() == 0) begin
                    checkOutput("done_unexpected", who, -1);
                end else begin
                    t = done_q.pop_front();
                    checkOutput("done_owner", who, t.owner);
                    checkOutput("prod_owner", (t.owner == 1) ? prod1 : prod0, t.prod);
                    checkOutput("prod_other", (t.owner == 1) ? prod0 : prod1, exp_prod[1 - t.owner]);
                    checkOutput("err_flag", err, t.err);
                    checkOutput("latency", cycle - gnt_cycle, t.err ? 2 + TIMEOUT : 2 + lat_last);
                    exp_prod[t.owner] = t.prod;
                end
            end else if (err) begin
                checkOutput("err_without_done", err, 0);
            end
        end
    end

    task automatic expectTxn(input int who, input logic [PW-1:0] p, input logic e);
        gnt_q.push_back(who);
        done_q.push_back('{who, p, e});
    endtask

    // Issue requests from idle; the model predicts grant order and results
    task automatic applyStimulus(input bit r0, input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] y0,
                                 input bit r1, input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] y1);
        int            first;
        logic [PW-1:0] p0;
        logic [PW-1:0] p1;
        p0 = stuck ? '0 : PW'(x0) * PW'(y0);
        p1 = stuck ? '0 : PW'(x1) * PW'(y1);
        first = (r0 && r1) ? 1 - model_last : (r1 ? 1 : 0);
        expectTxn(first, (first == 1) ? p1 : p0, stuck);
        if (r0 && r1) expectTxn(1 - first, (first == 1) ? p0 : p1, stuck);
        model_last = (r0 && r1) ? 1 - first : first;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        req0 = r0;
        req1 = r1;
    endtask

    // One clock: a requester drops its request once granted
    task automatic stepCycle();
        bit g0;
        bit g1;
        @(negedge clk);
        g0 = gnt0;
        g1 = gnt1;
        @(posedge clk);
        #1;
        if (g0) req0 = 1'b0;
        if (g1) req1 = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while ((done_q.size() != 0 || busy || req0 || req1) && n < bound) begin
            stepCycle();
            n++;
        end
        if (n >= bound) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idle_wait: still busy after %0d cycles, required idle", n);
            gnt_q.delete();
            done_q.delete();
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    // Pulse reset with requests high and verify every output sits at its reset value
    task automatic applyReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        gnt_q.delete();
        done_q.delete();
        exp_prod[0] = '0;
        exp_prod[1] = '0;
        model_last  = 1;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 8'hA5; b0 = 8'h5A; a1 = 8'h3C; b1 = 8'hC3;
        @(negedge clk);
        checkOutput("rst_gnt0", gnt0, 0);
        checkOutput("rst_gnt1", gnt1, 0);
        checkOutput("rst_done0", done0, 0);
        checkOutput("rst_done1", done1, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_prod0", prod0, 0);
        checkOutput("rst_prod1", prod1, 0);
        checkOutput("rst_mul_a", mul_a, 0);
        checkOutput("rst_mul_b", mul_b, 0);
        checkOutput("rst_mul_rst", mul_rst, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
    endtask

    initial begin
        int n;
        bit r0;
        bit r1;
        exp_prod[0] = '0;
        exp_prod[1] = '0;
        applyReset();

        // Single requesters
        applyStimulus(1, 8'd3, 8'd9, 0, 8'd0, 8'd0);
        waitIdle(60);
        applyStimulus(0, 8'd0, 8'd0, 1, 8'd100, 8'd14);
        waitIdle(60);
        applyStimulus(1, 8'd25, 8'd0, 0, 8'd0, 8'd0);
        waitIdle(60);

        // Simultaneous pair from reset: req0 first, req1 held off then served
        applyReset();
        applyStimulus(1, 8'd123, 8'd12, 1, 8'd45, 8'd69);
        n = 0;
        while (done_q.size() == 2 && n < 60) begin
            stepCycle();
            n++;
        end
        if (n >= 60) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL first_done_wait: %0d cycles, required fewer than 60", n);
        end
        // req0 re-raised while req1 still pending: req1 wins since req0 was served last
        a0 = 8'd200; b0 = 8'd2; req0 = 1'b1;
        expectTxn(0, 16'd400, 1'b0);
        model_last = 0;
        waitIdle(80);
        // Repeat the pair: req0 served last, so req1 goes first
        applyStimulus(1, 8'd123, 8'd12, 1, 8'd45, 8'd69);
        waitIdle(80);

        // Request raised and dropped while busy is never served
        force_lat = 6;
        applyStimulus(1, 8'd11, 8'd13, 0, 8'd0, 8'd0);
        repeat (3) stepCycle();
        a1 = 8'd99; b1 = 8'd99; req1 = 1'b1;
        repeat (2) stepCycle();
        req1 = 1'b0;
        waitIdle(60);

        // Request raised while busy and kept is served in the next IDLE
        applyStimulus(1, 8'd17, 8'd19, 0, 8'd0, 8'd0);
        repeat (3) stepCycle();
        a1 = 8'd7; b1 = 8'd250; req1 = 1'b1;
        expectTxn(1, 16'd1750, 1'b0);
        model_last = 1;
        waitIdle(60);

        // Reset in the middle of WAIT aborts with no done
        force_lat = 20;
        applyStimulus(1, 8'd5, 8'd7, 0, 8'd0, 8'd0);
        repeat (5) stepCycle();
        checkOutput("busy_before_abort", busy, 1);
        applyReset();
        force_lat = 0;
        applyStimulus(1, 8'd3, 8'd9, 0, 8'd0, 8'd0);
        waitIdle(60);

        // Multiplier that never answers
        stuck = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
        applyStimulus(1, 8'd77, 8'd3, 0, 8'd0, 8'd0);
        waitIdle(TIMEOUT + 20);
        stuck = 1'b0;
`else
        gnt_q.push_back(0);
        model_last = 0;
        a0 = 8'd7; b0 = 8'd7; req0 = 1'b1;
        repeat (TIMEOUT + 20) stepCycle();
        checkOutput("busy_without_timeout", busy, 1);
        applyReset();
        stuck = 1'b0;
`endif

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            applyStimulus(r0, WIDTH'($urandom), WIDTH'($urandom), r1, WIDTH'($urandom), WIDTH'($urandom));
            waitIdle(80);
        end

        repeat (3) stepCycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
